regfile_wb_scheduler: RTL and testbench

- Scoreboard and write-back scheduler in front of the 32x32 register file.
- Tracks which architectural registers have an in-flight write and stalls issue on RAW/WAW hazards.
- Arbitrates the single register-file write port between two write-back requesters: A = ALU pipe, B = load/memory pipe.
- Drives the register file's EnableWrite/write_reg/write_data from registered outputs.

---
 rtl/regfile_ctrl_pkg.sv | 16 +
 rtl/wb_rr_arbiter.sv | 47 ++++
 rtl/regfile_wb_scheduler.sv | 148 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package regfile_ctrl_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    // Identifies which write-back requester won the port.
    typedef enum logic {
        WB_A = 1'b0,
        WB_B = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
// req[0]/gnt[0] belong to requester A, req[1]/gnt[1] to requester B.
// gnt is combinational and is either one-hot or zero.
module wb_rr_arbiter
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e last_grant_q;
    wb_src_e last_grant_d;

    // Grant selection: a lone requester always wins; a contest goes to the
    // side that did not win last time.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == WB_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // History moves only when someone is actually granted.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[0]) begin
            last_grant_d = WB_A;
        end else if (gnt[1]) begin
            last_grant_d = WB_B;
        end
    end

    // Reset leaves B as last winner so A takes the first contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= WB_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Scoreboard and write-back scheduler in front of the 32x32 register file.
// Tracks in-flight destination registers, stalls issue on RAW/WAW hazards,
// arbitrates the single write port between the ALU (A) and load (B) pipes,
// and drives the register file write port from registered outputs.
// Optional build macro RF_ZERO_REG_EN: register 0 is never busy and
// write-backs to it are accepted but dropped.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W      = regfile_ctrl_pkg::DATA_W,
    parameter int ADDR_W      = regfile_ctrl_pkg::ADDR_W,
    parameter int NUM_REGS    = regfile_ctrl_pkg::NUM_REGS,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    // issue side
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [ADDR_W-1:0]      issue_rs1,
    input  logic [ADDR_W-1:0]      issue_rs2,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic                   issue_wen,
    // write-back requester A (ALU pipe)
    input  logic                   wba_valid,
    output logic                   wba_ready,
    input  logic [ADDR_W-1:0]      wba_rd,
    input  logic [DATA_W-1:0]      wba_data,
    // write-back requester B (load/memory pipe)
    input  logic                   wbb_valid,
    output logic                   wbb_ready,
    input  logic [ADDR_W-1:0]      wbb_rd,
    input  logic [DATA_W-1:0]      wbb_data,
    // register file write port
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    // status
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   wb_err
);

    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic [NUM_REGS-1:0]    set_vec, clr_vec;
    logic                   rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]      rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]      rf_wdata_q, rf_wdata_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   wb_err_q, wb_err_d;

    logic [1:0]             gnt;
    logic                   wb_fire;
    logic [ADDR_W-1:0]      wb_rd;
    logic [DATA_W-1:0]      wb_data;
    logic                   wb_to_zero;
    logic                   issue_fire;

    wb_rr_arbiter u_arb (
        .clk (clk),
        .rst (rst),
        .req ({wbb_valid, wba_valid}),
        .gnt (gnt)
    );

    assign wba_ready = gnt[0];
    assign wbb_ready = gnt[1];

    // Hazard check uses registered busy bits only; a write-back clearing a
    // register this cycle is seen by issue one cycle later.
    always_comb begin
        issue_ready = !(busy_q[issue_rs1] | busy_q[issue_rs2] |
                        (issue_wen & busy_q[issue_rd]));
        issue_fire  = issue_valid & issue_ready;
    end

    // Select the granted write-back and classify writes to register 0.
    always_comb begin
        wb_fire = |gnt;
        wb_rd   = gnt[1] ? wbb_rd   : wba_rd;
        wb_data = gnt[1] ? wbb_data : wba_data;
`ifdef RF_ZERO_REG_EN
        wb_to_zero = (wb_rd == '0);
`else
        wb_to_zero = 1'b0;
`endif
    end

    // Scoreboard next state: clears from write-back, sets from issue; a set
    // of the same register in the same cycle takes priority over the clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_fire && issue_wen) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (wb_fire) begin
            clr_vec[wb_rd] = 1'b1;
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
`ifdef RF_ZERO_REG_EN
        busy_d[0] = 1'b0;
`endif
    end

    // Write port, error flag and stall counter next state.
    always_comb begin
        rf_we_d    = wb_fire & ~wb_to_zero;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (rf_we_d) begin
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end
        wb_err_d = wb_err_q | (wb_fire & ~wb_to_zero & ~busy_q[wb_rd]);
        stall_d  = stall_q;
        if (issue_valid && !issue_ready && !(&stall_q)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State registers; reset discards anything in flight this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            stall_q    <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            stall_q    <= stall_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign busy_vec  = busy_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign stall_cnt = stall_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed testbench for regfile_wb_scheduler. Expected values are
// hand-derived; zero-register expectations follow RF_ZERO_REG_EN.
module tb_regfile_wb_scheduler;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_ready, issue_wen;
    logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          wba_valid, wba_ready, wbb_valid, wbb_ready;
    logic [AW-1:0] wba_rd, wbb_rd;
    logic [DW-1:0] wba_data, wbb_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [NR-1:0] busy_vec;
    logic [SW-1:0] stall_cnt;
    logic          wb_err;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wen   (issue_wen),
        .wba_valid   (wba_valid),
        .wba_ready   (wba_ready),
        .wba_rd      (wba_rd),
        .wba_data    (wba_data),
        .wbb_valid   (wbb_valid),
        .wbb_ready   (wbb_ready),
        .wbb_rd      (wbb_rd),
        .wbb_data    (wbb_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy_vec    (busy_vec),
        .stall_cnt   (stall_cnt),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic wen);
        issue_valid = v;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_wen   = wen;
    endtask

    task automatic wba(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        wba_valid = v;
        wba_rd    = rd;
        wba_data  = d;
    endtask

    task automatic wbb(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        wbb_valid = v;
        wbb_rd    = rd;
        wbb_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        issue(1'b0, '0, '0, '0, 1'b0);
        wba(1'b0, '0, '0);
        wbb(1'b0, '0, '0);
        do_reset();
        #1;
        chk("rst_busy", 64'(busy_vec), 64'h0);
        chk("rst_we", 64'(rf_we), 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        chk("rst_err", 64'(wb_err), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h1);

        // RAW hazard on r9
        issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        #1 chk("raw_issue_ready", 64'(issue_ready), 64'h1);
        tick();
        issue(1'b0, '0, '0, '0, 1'b0);
        chk("raw_busy9_set", 64'(busy_vec), 64'h0000_0200);
        issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        #1 chk("raw_stall_ready", 64'(issue_ready), 64'h0);
        tick();
        chk("raw_stall_cnt1", 64'(stall_cnt), 64'h1);
        tick();
        chk("raw_stall_cnt2", 64'(stall_cnt), 64'h2);
        issue(1'b0, 5'd9, 5'd0, 5'd0, 1'b0);
        wba(1'b1, 5'd9, 32'd66);
        #1 chk("raw_wba_ready", 64'(wba_ready), 64'h1);
        tick();
        wba(1'b0, '0, '0);
        chk("raw_rf_we", 64'(rf_we), 64'h1);
        chk("raw_rf_waddr", 64'(rf_waddr), 64'd9);
        chk("raw_rf_wdata", 64'(rf_wdata), 64'd66);
        chk("raw_busy9_clr", 64'(busy_vec), 64'h0);
        chk("raw_stall_hold", 64'(stall_cnt), 64'h2);
        issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        #1 chk("raw_ready_after", 64'(issue_ready), 64'h1);
        tick();
        issue(1'b0, '0, '0, '0, 1'b0);
        chk("idle_we", 64'(rf_we), 64'h0);
        chk("idle_waddr_hold", 64'(rf_waddr), 64'd9);
        chk("idle_wdata_hold", 64'(rf_wdata), 64'd66);

        // Round robin: fresh reset so A wins the first contest
        do_reset();
        #1;
        issue(1'b1, 5'd0, 5'd0, 5'd10, 1'b1);
        tick();
        issue(1'b1, 5'd0, 5'd0, 5'd16, 1'b1);
        tick();
        issue(1'b0, '0, '0, '0, 1'b0);
        chk("rr_busy", 64'(busy_vec), 64'h0001_0400);
        wba(1'b1, 5'd10, 32'd4);
        wbb(1'b1, 5'd16, 32'd232);
        #1 chk("rr1_gnt", 64'({wbb_ready, wba_ready}), 64'b01);
        tick();
        chk("rr1_waddr", 64'(rf_waddr), 64'd10);
        chk("rr1_wdata", 64'(rf_wdata), 64'd4);
        chk("rr1_busy", 64'(busy_vec), 64'h0001_0000);
        wba(1'b0, '0, '0);
        #1 chk("rr2_gnt", 64'({wbb_ready, wba_ready}), 64'b10);
        tick();
        chk("rr2_waddr", 64'(rf_waddr), 64'd16);
        chk("rr2_wdata", 64'(rf_wdata), 64'd232);
        chk("rr2_busy", 64'(busy_vec), 64'h0);
        chk("rr2_err", 64'(wb_err), 64'h0);
        wba(1'b1, 5'd10, 32'd5);
        wbb(1'b1, 5'd16, 32'd7);
        #1 chk("rr3_gnt", 64'({wbb_ready, wba_ready}), 64'b01);
        tick();
        chk("rr3_waddr", 64'(rf_waddr), 64'd10);
        chk("rr3_wdata", 64'(rf_wdata), 64'd5);
        chk("rr3_err", 64'(wb_err), 64'h1);
        #1 chk("rr4_gnt", 64'({wbb_ready, wba_ready}), 64'b10);
        tick();
        chk("rr4_waddr", 64'(rf_waddr), 64'd16);
        chk("rr4_wdata", 64'(rf_wdata), 64'd7);
        wba(1'b0, '0, '0);
        wbb(1'b0, '0, '0);

        // Reset in the middle of traffic
        issue(1'b1, 5'd0, 5'd0, 5'd19, 1'b1);
        tick();
        issue(1'b1, 5'd19, 5'd0, 5'd0, 1'b0);
        tick();
        chk("mid_stall_pre", 64'(stall_cnt), 64'h1);
        wba(1'b1, 5'd19, 32'd77);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        issue(1'b0, '0, '0, '0, 1'b0);
        wba(1'b0, '0, '0);
        #1;
        chk("mid_busy", 64'(busy_vec), 64'h0);
        chk("mid_we", 64'(rf_we), 64'h0);
        chk("mid_waddr", 64'(rf_waddr), 64'h0);
        chk("mid_stall", 64'(stall_cnt), 64'h0);
        chk("mid_err", 64'(wb_err), 64'h0);

        // WAW on r19
        issue(1'b1, 5'd0, 5'd0, 5'd19, 1'b1);
        tick();
        chk("waw_busy19", 64'(busy_vec), 64'h0008_0000);
        issue(1'b1, 5'd1, 5'd2, 5'd19, 1'b1);
        #1 chk("waw_ready_wen1", 64'(issue_ready), 64'h0);
        issue(1'b1, 5'd1, 5'd2, 5'd19, 1'b0);
        #1 chk("waw_ready_wen0", 64'(issue_ready), 64'h1);
        issue(1'b1, 5'd1, 5'd19, 5'd3, 1'b0);
        #1 chk("waw_ready_rs2", 64'(issue_ready), 64'h0);
        issue(1'b0, '0, '0, '0, 1'b0);

        // Write-back to a non-busy register
        wbb(1'b1, 5'd21, 32'd40);
        #1 chk("err_gnt", 64'({wbb_ready, wba_ready}), 64'b10);
        tick();
        wbb(1'b0, '0, '0);
        chk("err_we", 64'(rf_we), 64'h1);
        chk("err_waddr", 64'(rf_waddr), 64'd21);
        chk("err_wdata", 64'(rf_wdata), 64'd40);
        chk("err_set", 64'(wb_err), 64'h1);
        tick();
        tick();
        chk("err_sticky", 64'(wb_err), 64'h1);
        chk("err_busy", 64'(busy_vec), 64'h0008_0000);

        // Same-cycle set and clear of r5: set wins
        issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        wba(1'b1, 5'd5, 32'd9);
        tick();
        issue(1'b0, '0, '0, '0, 1'b0);
        wba(1'b0, '0, '0);
        chk("setclr_busy", 64'(busy_vec), 64'h0008_0020);
        chk("setclr_waddr", 64'(rf_waddr), 64'd5);
        wba(1'b1, 5'd5, 32'd11);
        tick();
        wba(1'b1, 5'd19, 32'd12);
        tick();
        wba(1'b0, '0, '0);
        chk("drain_busy", 64'(busy_vec), 64'h0);

        // Register 0 handling
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        issue(1'b0, '0, '0, '0, 1'b0);
`ifdef RF_ZERO_REG_EN
        chk("zero_busy", 64'(busy_vec), 64'h0);
`else
        chk("zero_busy", 64'(busy_vec), 64'h1);
`endif
        wba(1'b1, 5'd0, 32'd123);
        #1 chk("zero_ready", 64'(wba_ready), 64'h1);
        tick();
        wba(1'b0, '0, '0);
`ifdef RF_ZERO_REG_EN
        chk("zero_we", 64'(rf_we), 64'h0);
        chk("zero_waddr_hold", 64'(rf_waddr), 64'd19);
`else
        chk("zero_we", 64'(rf_we), 64'h1);
        chk("zero_waddr", 64'(rf_waddr), 64'd0);
        chk("zero_wdata", 64'(rf_wdata), 64'd123);
`endif
        chk("zero_busy_clr", 64'(busy_vec), 64'h0);

        // Final reset clears the sticky error
        do_reset();
        #1 chk("final_err", 64'(wb_err), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
